// File: rtl/cpu_params_pkg.sv
// Shared CPU constants and types for the memory-mapped timer/IRQ window.
// Holds the register width, default MMR window map, the target-select enum,
// the bus-interface FSM state enum and the write-strobe bundle.
package cpu_params_pkg;

    localparam int unsigned RSZ = 32;

    localparam logic [31:0] MMR_BASE_DFLT  = 32'h0200_0000;
    localparam logic [15:0] MSIP_OFS_DFLT  = 16'h0000;
    localparam logic [15:0] MTCMP_OFS_DFLT = 16'h4000;
    localparam logic [15:0] MTIME_OFS_DFLT = 16'hBFF8;

    typedef enum logic [2:0] {
        MMR_NONE,
        MMR_MSIP,
        MMR_MTCMP_LO,
        MMR_MTCMP_HI,
        MMR_MTIME_LO,
        MMR_MTIME_HI
    } mmr_sel_t;

    typedef enum logic {
        ST_IDLE,
        ST_RESP
    } mmr_state_t;

    // One-cycle write strobes towards irq
    typedef struct packed {
        logic msip;
        logic mtcmp_lo;
        logic mtcmp_hi;
        logic mtime_lo;
        logic mtime_hi;
    } mmr_strb_t;

endpackage

// File: rtl/mmr_decode.sv
// Combinational address decoder for the MMR window.
// Ports: req_addr (byte address) in; sel_c (decoded target) and err_c
// (misaligned, outside the window, or unmapped offset) out.
module mmr_decode
    import cpu_params_pkg::*;
#(
    parameter logic [31:0] MMR_BASE  = MMR_BASE_DFLT,
    parameter logic [15:0] MSIP_OFS  = MSIP_OFS_DFLT,
    parameter logic [15:0] MTCMP_OFS = MTCMP_OFS_DFLT,
    parameter logic [15:0] MTIME_OFS = MTIME_OFS_DFLT
) (
    input  logic [RSZ-1:0] req_addr,
    output mmr_sel_t       sel_c,
    output logic           err_c
);

    localparam logic [15:0] MTCMP_HI_OFS = MTCMP_OFS + 16'd4;
    localparam logic [15:0] MTIME_HI_OFS = MTIME_OFS + 16'd4;

    logic [15:0] ofs;
    logic        in_window;

    assign ofs       = req_addr[15:0];
    assign in_window = (req_addr[RSZ-1:16] == MMR_BASE[RSZ-1:16]);

    // Offset lookup; anything misaligned or outside the window decodes to NONE
    always_comb begin
        sel_c = MMR_NONE;
        if (ofs == MSIP_OFS)          sel_c = MMR_MSIP;
        else if (ofs == MTCMP_OFS)    sel_c = MMR_MTCMP_LO;
        else if (ofs == MTCMP_HI_OFS) sel_c = MMR_MTCMP_HI;
        else if (ofs == MTIME_OFS)    sel_c = MMR_MTIME_LO;
        else if (ofs == MTIME_HI_OFS) sel_c = MMR_MTIME_HI;
        if (!in_window || (req_addr[1:0] != 2'b00)) sel_c = MMR_NONE;
        err_c = (sel_c == MMR_NONE);
    end

endmodule

// File: rtl/mmr_bus_if.sv
// Slave bus interface for the timer/IRQ register window.
// Accepts one MEM-stage request at a time (IDLE -> RESP -> IDLE), produces
// one-cycle write strobes plus registered write data for irq, and returns
// registered read data / error on a valid/ready response channel.
// Ports: clk_in, reset_in (async active-low); req_* request channel;
// rsp_* response channel; *_wr strobes and mmr_wr_data to irq;
// mtime, mtimecmp, sw_irq from irq.
// Config: MMR_SNAPSHOT_EN builds an mtime high-word shadow latched on a
// low-word read, giving atomic 64-bit mtime reads.
module mmr_bus_if
    import cpu_params_pkg::*;
#(
    parameter logic [31:0] MMR_BASE  = MMR_BASE_DFLT,
    parameter logic [15:0] MSIP_OFS  = MSIP_OFS_DFLT,
    parameter logic [15:0] MTCMP_OFS = MTCMP_OFS_DFLT,
    parameter logic [15:0] MTIME_OFS = MTIME_OFS_DFLT
) (
    input  logic             clk_in,
    input  logic             reset_in,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_wr,
    input  logic [RSZ-1:0]   req_addr,
    input  logic [RSZ-1:0]   req_wr_data,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [RSZ-1:0]   rsp_rd_data,
    output logic             rsp_err,
    output logic             mtime_lo_wr,
    output logic             mtime_hi_wr,
    output logic             mtimecmp_lo_wr,
    output logic             mtimecmp_hi_wr,
    output logic             msip_wr,
    output logic [RSZ-1:0]   mmr_wr_data,
    input  logic [2*RSZ-1:0] mtime,
    input  logic [2*RSZ-1:0] mtimecmp,
    input  logic             sw_irq
);

    mmr_state_t     state_q, state_d;
    mmr_strb_t      strb_q, strb_d;
    logic [RSZ-1:0] rd_data_q, rd_data_d;
    logic [RSZ-1:0] wr_data_q, wr_data_d;
    logic           err_q, err_d;
    mmr_sel_t       dec_sel;
    logic           dec_err;
    logic           accept_c;
    logic [RSZ-1:0] rd_val_c;
    logic [RSZ-1:0] mtime_hi_val_c;

    mmr_decode #(
        .MMR_BASE  (MMR_BASE),
        .MSIP_OFS  (MSIP_OFS),
        .MTCMP_OFS (MTCMP_OFS),
        .MTIME_OFS (MTIME_OFS)
    ) u_decode (
        .req_addr (req_addr),
        .sel_c    (dec_sel),
        .err_c    (dec_err)
    );

    assign accept_c = (state_q == ST_IDLE) && req_valid;

`ifdef MMR_SNAPSHOT_EN
    logic [RSZ-1:0] shadow_q, shadow_d;

    // Latch the upper mtime half whenever the low word is read
    always_comb begin
        shadow_d = shadow_q;
        if (accept_c && !req_wr && (dec_sel == MMR_MTIME_LO)) shadow_d = mtime[2*RSZ-1:RSZ];
    end

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) shadow_q <= '0;
        else           shadow_q <= shadow_d;
    end

    assign mtime_hi_val_c = shadow_q;
`else
    assign mtime_hi_val_c = mtime[2*RSZ-1:RSZ];
`endif

    // Read mux over live irq values
    always_comb begin
        rd_val_c = '0;
        case (dec_sel)
            MMR_MSIP:     rd_val_c = {(RSZ-4)'(0), sw_irq, 3'b000};
            MMR_MTCMP_LO: rd_val_c = mtimecmp[RSZ-1:0];
            MMR_MTCMP_HI: rd_val_c = mtimecmp[2*RSZ-1:RSZ];
            MMR_MTIME_LO: rd_val_c = mtime[RSZ-1:0];
            MMR_MTIME_HI: rd_val_c = mtime_hi_val_c;
            default:      rd_val_c = '0;
        endcase
    end

    // Next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (req_valid) state_d = ST_RESP;
            ST_RESP: if (rsp_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Handshake outputs decoded from state
    always_comb begin
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        case (state_q)
            ST_IDLE: req_ready = 1'b1;
            ST_RESP: rsp_valid = 1'b1;
            default: req_ready = 1'b0;
        endcase
    end

    // Capture on accept; strobes self-clear since RESP never accepts
    always_comb begin
        rd_data_d = rd_data_q;
        wr_data_d = wr_data_q;
        err_d     = err_q;
        strb_d    = '0;
        if (accept_c) begin
            wr_data_d = req_wr_data;
            err_d     = dec_err;
            rd_data_d = (req_wr || dec_err) ? '0 : rd_val_c;
            if (req_wr && !dec_err) begin
                strb_d.msip     = (dec_sel == MMR_MSIP);
                strb_d.mtcmp_lo = (dec_sel == MMR_MTCMP_LO);
                strb_d.mtcmp_hi = (dec_sel == MMR_MTCMP_HI);
                strb_d.mtime_lo = (dec_sel == MMR_MTIME_LO);
                strb_d.mtime_hi = (dec_sel == MMR_MTIME_HI);
            end
        end
    end

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            state_q   <= ST_IDLE;
            strb_q    <= '0;
            rd_data_q <= '0;
            wr_data_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            strb_q    <= strb_d;
            rd_data_q <= rd_data_d;
            wr_data_q <= wr_data_d;
            err_q     <= err_d;
        end
    end

    assign rsp_rd_data    = rd_data_q;
    assign rsp_err        = err_q;
    assign mmr_wr_data    = wr_data_q;
    assign msip_wr        = strb_q.msip;
    assign mtimecmp_lo_wr = strb_q.mtcmp_lo;
    assign mtimecmp_hi_wr = strb_q.mtcmp_hi;
    assign mtime_lo_wr    = strb_q.mtime_lo;
    assign mtime_hi_wr    = strb_q.mtime_hi;

endmodule

// File: tb/tb_mmr_bus_if.sv
// Directed self-checking bench for mmr_bus_if with a tiny irq model
// (mtimecmp / sw_irq follow the write strobes; mtime is driven directly).
module tb_mmr_bus_if;

    logic        clk_in = 1'b0;
    logic        reset_in;
    logic        req_valid, req_ready, req_wr;
    logic [31:0] req_addr, req_wr_data;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_rd_data;
    logic        rsp_err;
    logic        mtime_lo_wr, mtime_hi_wr, mtimecmp_lo_wr, mtimecmp_hi_wr, msip_wr;
    logic [31:0] mmr_wr_data;
    logic [63:0] mtime;
    logic [63:0] mtimecmp = 64'h0;
    logic        sw_irq = 1'b0;
    logic [4:0]  stb_now;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk_in = ~clk_in;

    assign stb_now = {msip_wr, mtimecmp_lo_wr, mtimecmp_hi_wr, mtime_lo_wr, mtime_hi_wr};

    mmr_bus_if dut (
        .clk_in         (clk_in),
        .reset_in       (reset_in),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_wr         (req_wr),
        .req_addr       (req_addr),
        .req_wr_data    (req_wr_data),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_rd_data    (rsp_rd_data),
        .rsp_err        (rsp_err),
        .mtime_lo_wr    (mtime_lo_wr),
        .mtime_hi_wr    (mtime_hi_wr),
        .mtimecmp_lo_wr (mtimecmp_lo_wr),
        .mtimecmp_hi_wr (mtimecmp_hi_wr),
        .msip_wr        (msip_wr),
        .mmr_wr_data    (mmr_wr_data),
        .mtime          (mtime),
        .mtimecmp       (mtimecmp),
        .sw_irq         (sw_irq)
    );

    // Minimal irq register model
    always @(posedge clk_in) begin
        if (mtimecmp_lo_wr) mtimecmp[31:0]  <= mmr_wr_data;
        if (mtimecmp_hi_wr) mtimecmp[63:32] <= mmr_wr_data;
        if (msip_wr)        sw_irq          <= mmr_wr_data[3];
    end

    // One full access: drive, observe first RESP cycle, stall 'hold' cycles, retire.
    // mtime switches to mtime_after right after the accept edge.
    task automatic access(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                          input int hold, input logic [63:0] mtime_after,
                          output logic [31:0] rd, output logic err, output logic [4:0] stb1,
                          output logic [31:0] wd, output logic hs_ok, output logic [4:0] stb_rest);
        @(negedge clk_in);
        req_valid = 1'b1; req_wr = wr; req_addr = addr; req_wr_data = data;
        for (int i = 0; i < 20 && req_ready !== 1'b1; i++) @(negedge clk_in);
        @(negedge clk_in);
        req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_wr_data = '0;
        mtime = mtime_after;
        hs_ok = (rsp_valid === 1'b1) && (req_ready === 1'b0);
        stb1 = stb_now; rd = rsp_rd_data; err = rsp_err; wd = mmr_wr_data;
        stb_rest = '0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk_in);
            if (rsp_rd_data !== rd || rsp_err !== err || rsp_valid !== 1'b1 || req_ready !== 1'b0)
                hs_ok = 1'b0;
            stb_rest |= stb_now;
        end
        rsp_ready = 1'b1;
        @(negedge clk_in);
        rsp_ready = 1'b0;
        stb_rest |= stb_now;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) hs_ok = 1'b0;
    endtask

    logic [31:0] rd, wd;
    logic        err, ok;
    logic [4:0]  s1, sr;

    task automatic test_reset();
        reset_in = 1'b0; req_valid = 1'b1; req_wr = 1'b1;
        req_addr = 32'h0200_4000; req_wr_data = 32'hDEAD_BEEF;
        repeat (3) @(negedge clk_in);
        vectors++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_hs: ready=%b valid=%b want 1/0", req_ready, rsp_valid);
        end
        vectors++;
        if (stb_now !== 5'b0 || rsp_rd_data !== 32'h0 || mmr_wr_data !== 32'h0 || rsp_err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_regs: stb=%b rd=%h wd=%h err=%b want all 0", stb_now, rsp_rd_data, mmr_wr_data, rsp_err);
        end
        req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_wr_data = '0;
        reset_in = 1'b1;
        access(1'b0, 32'h0200_BFF8, 32'h0, 0, mtime, rd, err, s1, wd, ok, sr);
        vectors++;
        if (rd !== 32'hA5A5_0001 || err !== 1'b0 || !ok || s1 !== 5'b0) begin
            miscompares++;
            $display("FAIL first_access: rd=%h err=%b hs=%b stb=%b want a5a50001/0/1/00000", rd, err, ok, s1);
        end
    endtask

    task automatic test_write_mtimecmp();
        access(1'b1, 32'h0200_4000, 32'h0000_1234, 0, mtime, rd, err, s1, wd, ok, sr);
        vectors++;
        if (s1 !== 5'b01000 || sr !== 5'b0) begin
            miscompares++;
            $display("FAIL cmp_lo_strobe: first=%b later=%b want 01000/00000", s1, sr);
        end
        vectors++;
        if (wd !== 32'h1234 || err !== 1'b0 || rd !== 32'h0 || !ok) begin
            miscompares++;
            $display("FAIL cmp_lo_wr: wd=%h err=%b rd=%h hs=%b want 1234/0/0/1", wd, err, rd, ok);
        end
        access(1'b0, 32'h0200_4000, 32'h0, 0, mtime, rd, err, s1, wd, ok, sr);
        vectors++;
        if (rd !== 32'h1234 || err !== 1'b0 || s1 !== 5'b0) begin
            miscompares++;
            $display("FAIL cmp_lo_readback: rd=%h err=%b stb=%b want 1234/0/00000", rd, err, s1);
        end
        access(1'b1, 32'h0200_4004, 32'h0000_CAFE, 0, mtime, rd, err, s1, wd, ok, sr);
        vectors++;
        if (s1 !== 5'b00100 || wd !== 32'hCAFE) begin
            miscompares++;
            $display("FAIL cmp_hi_strobe: stb=%b wd=%h want 00100/cafe", s1, wd);
        end
        access(1'b0, 32'h0200_4004, 32'h0, 0, mtime, rd, err, s1, wd, ok, sr);
        vectors++;
        if (rd !== 32'hCAFE) begin
            miscompares++;
            $display("FAIL cmp_hi_readback: rd=%h want cafe", rd);
        end
    endtask

    task automatic test_read_stall();
        mtime = 64'h0000_0007_1357_9BDF;
        access(1'b0, 32'h0200_BFF8, 32'h0, 5, 64'h0000_0007_0000_0000, rd, err, s1, wd, ok, sr);
        vectors++;
        if (rd !== 32'h1357_9BDF || err !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_rd: rd=%h err=%b want 13579bdf/0", rd, err);
        end
        vectors++;
        if (!ok || s1 !== 5'b0 || sr !== 5'b0) begin
            miscompares++;
            $display("FAIL stall_stable: hs=%b stb=%b/%b want 1/00000/00000", ok, s1, sr);
        end
        access(1'b0, 32'h0200_BFFC, 32'h0, 0, mtime, rd, err, s1, wd, ok, sr);
        vectors++;
        if (rd !== 32'h7 || err !== 1'b0) begin
            miscompares++;
            $display("FAIL mtime_hi_rd: rd=%h err=%b want 7/0", rd, err);
        end
    endtask

    task automatic test_errors();
        logic [31:0] addrs [4];
        logic        wrs [4];
        addrs = '{32'h0200_0002, 32'h0200_0100, 32'h0300_4000, 32'h0200_4001};
        wrs   = '{1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            access(wrs[i], addrs[i], 32'hFFFF_FFFF, 1, mtime, rd, err, s1, wd, ok, sr);
            vectors++;
            if (err !== 1'b1 || rd !== 32'h0 || s1 !== 5'b0 || sr !== 5'b0 || !ok) begin
                miscompares++;
                $display("FAIL err_%h: err=%b rd=%h stb=%b/%b hs=%b want 1/0/00000/00000/1",
                         addrs[i], err, rd, s1, sr, ok);
            end
        end
    endtask

    task automatic test_msip();
        access(1'b1, 32'h0200_0000, 32'h8, 0, mtime, rd, err, s1, wd, ok, sr);
        vectors++;
        if (s1 !== 5'b10000 || sr !== 5'b0 || wd !== 32'h8 || err !== 1'b0) begin
            miscompares++;
            $display("FAIL msip_wr: stb=%b/%b wd=%h err=%b want 10000/00000/8/0", s1, sr, wd, err);
        end
        access(1'b0, 32'h0200_0000, 32'h0, 0, mtime, rd, err, s1, wd, ok, sr);
        vectors++;
        if (rd !== 32'h8) begin
            miscompares++;
            $display("FAIL msip_rd_set: rd=%h want 8", rd);
        end
        access(1'b1, 32'h0200_0000, 32'h0, 0, mtime, rd, err, s1, wd, ok, sr);
        access(1'b0, 32'h0200_0000, 32'h0, 0, mtime, rd, err, s1, wd, ok, sr);
        vectors++;
        if (rd !== 32'h0) begin
            miscompares++;
            $display("FAIL msip_rd_clr: rd=%h want 0", rd);
        end
    endtask

    task automatic test_snapshot();
        logic [31:0] exp_hi;
`ifdef MMR_SNAPSHOT_EN
        exp_hi = 32'h0;
`else
        exp_hi = 32'h1;
`endif
        mtime = 64'h0000_0000_FFFF_FFFE;
        access(1'b0, 32'h0200_BFF8, 32'h0, 0, 64'h0000_0001_0000_0002, rd, err, s1, wd, ok, sr);
        vectors++;
        if (rd !== 32'hFFFF_FFFE) begin
            miscompares++;
            $display("FAIL snap_lo: rd=%h want fffffffe", rd);
        end
        repeat (4) @(negedge clk_in);
        access(1'b0, 32'h0200_BFFC, 32'h0, 0, mtime, rd, err, s1, wd, ok, sr);
        vectors++;
        if (rd !== exp_hi) begin
            miscompares++;
            $display("FAIL snap_hi: rd=%h want %h", rd, exp_hi);
        end
    endtask

    task automatic test_mid_reset();
        @(negedge clk_in);
        req_valid = 1'b1; req_wr = 1'b1; req_addr = 32'h0200_BFF8; req_wr_data = 32'h55;
        @(negedge clk_in);
        req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_wr_data = '0;
        reset_in = 1'b0;
        #1;
        vectors++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || stb_now !== 5'b0 || mmr_wr_data !== 32'h0) begin
            miscompares++;
            $display("FAIL mid_reset: valid=%b ready=%b stb=%b wd=%h want 0/1/00000/0",
                     rsp_valid, req_ready, stb_now, mmr_wr_data);
        end
        @(negedge clk_in);
        reset_in = 1'b1;
        mtime = 64'h0000_0000_0000_0042;
        access(1'b0, 32'h0200_BFF8, 32'h0, 0, mtime, rd, err, s1, wd, ok, sr);
        vectors++;
        if (rd !== 32'h42 || !ok) begin
            miscompares++;
            $display("FAIL post_reset_rd: rd=%h hs=%b want 42/1", rd, ok);
        end
    endtask

    task automatic test_back_to_back();
        int accepts;
        accepts = 0;
        @(negedge clk_in);
        req_valid = 1'b1; req_wr = 1'b0; req_addr = 32'h0200_0000; rsp_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (req_ready === 1'b1) accepts++;
            @(negedge clk_in);
        end
        req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b0;
        @(negedge clk_in);
        vectors++;
        if (accepts != 5) begin
            miscompares++;
            $display("FAIL back_to_back: accepts=%0d in 10 cycles want 5", accepts);
        end
    endtask

    initial begin
        reset_in = 1'b0; req_valid = 1'b0; req_wr = 1'b0; req_addr = '0;
        req_wr_data = '0; rsp_ready = 1'b0;
        mtime = 64'h0000_0005_A5A5_0001;
        test_reset();
        test_write_mtimecmp();
        test_read_stall();
        test_errors();
        test_msip();
        test_snapshot();
        test_mid_reset();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
